// File: rtl/qcu_bus_pkg.sv
// Purpose: shared types and constants for the qcu bus master.
//   bus_op_e    : command opcodes (WRITE/READ/POLL/RSVD)
//   bus_cmd_t   : queued command payload (op, addr, wdata, mask)
//   bus_rsp_t   : queued response payload (timeout, data)
//   bus_state_e : bus master sequencing states
//   PHYS_BASE   : base address of the physics-engine peripheral window
package qcu_bus_pkg;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;

   localparam logic [ADDR_W-1:0] PHYS_BASE = 32'h4000_0000;

   typedef enum logic [1:0] {
      WRITE = 2'd0,
      READ  = 2'd1,
      POLL  = 2'd2,
      RSVD  = 2'd3
   } bus_op_e;

   typedef struct packed {
      bus_op_e           op;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
      logic [DATA_W-1:0] mask;
   } bus_cmd_t;

   typedef struct packed {
      logic              timeout;
      logic [DATA_W-1:0] data;
   } bus_rsp_t;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_ISSUE    = 3'd1,
      ST_CAPTURE  = 3'd2,
      ST_POLL_GAP = 3'd3,
      ST_RSP_WAIT = 3'd4
   } bus_state_e;

   // Masked compare used to terminate a poll.
   function automatic logic poll_match(input logic [DATA_W-1:0] rdata,
                                       input logic [DATA_W-1:0] expected,
                                       input logic [DATA_W-1:0] mask);
      return (rdata & mask) == (expected & mask);
   endfunction

endpackage

// File: rtl/qcu_bus_master_if.sv
// Purpose: bundles the command, response and peripheral-bus signals of the
// qcu bus master.
//   master modport : the bus master's view (drives cmd_ready, rsp_*, bus_*)
//   slave modport  : the environment's view (drives cmd_*, rsp_ready, bus_rdata)
interface qcu_bus_master_if;

   // command channel
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_op;
   logic [31:0] cmd_addr;
   logic [31:0] cmd_wdata;
   logic [31:0] cmd_mask;

   // response channel
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_data;
   logic        rsp_timeout;

   // peripheral bus
   logic        bus_cs;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic [31:0] bus_rdata;

   modport master (
      input  cmd_valid, cmd_op, cmd_addr, cmd_wdata, cmd_mask,
      output cmd_ready,
      output rsp_valid, rsp_data, rsp_timeout,
      input  rsp_ready,
      output bus_cs, bus_we, bus_addr, bus_wdata,
      input  bus_rdata
   );

   modport slave (
      output cmd_valid, cmd_op, cmd_addr, cmd_wdata, cmd_mask,
      input  cmd_ready,
      input  rsp_valid, rsp_data, rsp_timeout,
      output rsp_ready,
      input  bus_cs, bus_we, bus_addr, bus_wdata,
      output bus_rdata
   );

endinterface

// File: rtl/qcu_sync_fifo.sv
// Purpose: single-clock FIFO with extra-MSB pointers; simultaneous push and
// pop allowed at any occupancy, no empty-to-output bypass.
//   clk, rst   : clock, asynchronous active-high reset (discards contents)
//   i_push     : write request (accepted if not full, or full and popping)
//   i_wdata    : write data
//   i_pop      : read request (ignored when empty)
//   o_rdata_c  : head entry, zero when empty
//   o_full_c   : FIFO full
//   o_empty_c  : FIFO empty
module qcu_sync_fifo #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_rdata_c,
   output logic             o_full_c,
   output logic             o_empty_c
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;

   logic [PW-1:0]    r_wr_ptr;
   logic [PW-1:0]    r_rd_ptr;
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic             w_push;
   logic             w_pop;

   assign o_empty_c = (r_wr_ptr == r_rd_ptr);
   assign o_full_c  = (r_wr_ptr[PW-1] != r_rd_ptr[PW-1]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

   // A full FIFO frees its head slot in the same cycle it is popped.
   assign w_pop  = i_pop && !o_empty_c;
   assign w_push = i_push && (!o_full_c || w_pop);

   assign o_rdata_c = o_empty_c ? '0 : r_mem[r_rd_ptr[AW-1:0]];

   // Pointer update; reset empties the FIFO.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      end
   end

   // Storage array.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
   end

endmodule

// File: rtl/qcu_bus_master.sv
// Purpose: command-driven bus master. Queued WRITE/READ/POLL commands are
// issued as single peripheral-bus transactions; READ and POLL results are
// queued for the requester.
//   clk, rst : clock, asynchronous active-high reset
//   bus_if   : command, response and peripheral-bus signals (master modport)
//   busy     : sequencer active or commands pending
//   err_op   : sticky flag, a reserved opcode was received
module qcu_bus_master
   import qcu_bus_pkg::*;
#(
   parameter int unsigned CMD_DEPTH  = 8,
   parameter int unsigned RSP_DEPTH  = 8,
   parameter int unsigned POLL_LIMIT = 1024
) (
   input  logic               clk,
   input  logic               rst,
   qcu_bus_master_if.master   bus_if,
   output logic               busy,
   output logic               err_op
);

   localparam int unsigned CNT_W = $clog2(POLL_LIMIT + 1);
   localparam int unsigned CMD_W = $bits(bus_cmd_t);
   localparam int unsigned RSP_W = $bits(bus_rsp_t);

   bus_state_e        r_state;
   bus_state_e        w_next;
   bus_cmd_t          r_cmd;
   logic [CNT_W-1:0]  r_poll_cnt;
   logic [DATA_W-1:0] r_rdata;
   logic              r_timeout;
   logic              r_err_op;
   logic              r_bus_cs;
   logic              r_bus_we;
   logic [ADDR_W-1:0] r_bus_addr;
   logic [DATA_W-1:0] r_bus_wdata;

   bus_cmd_t          w_cmd_in;
   bus_cmd_t          w_cmd_head;
   logic              w_cmd_push;
   logic              w_cmd_pop;
   logic              w_cmd_full;
   logic              w_cmd_empty;
   bus_rsp_t          w_rsp_in;
   bus_rsp_t          w_rsp_head;
   logic              w_rsp_push;
   logic              w_rsp_full;
   logic              w_rsp_empty;
   logic              w_rsp_can_push;
   logic              w_set_err;
   logic              w_capture;
   logic              w_cap_timeout;
   logic              w_issue;
   bus_op_e           w_issue_op;
   logic [ADDR_W-1:0] w_issue_addr;
   logic [DATA_W-1:0] w_issue_wdata;

   // Command queue.
   assign w_cmd_in = '{op:    bus_op_e'(bus_if.cmd_op),
                       addr:  bus_if.cmd_addr,
                       wdata: bus_if.cmd_wdata,
                       mask:  bus_if.cmd_mask};
   assign w_cmd_push = bus_if.cmd_valid && !w_cmd_full;

   qcu_sync_fifo #(
      .WIDTH (CMD_W),
      .DEPTH (CMD_DEPTH)
   ) u_cmd_fifo (
      .clk       (clk),
      .rst       (rst),
      .i_push    (w_cmd_push),
      .i_wdata   (w_cmd_in),
      .i_pop     (w_cmd_pop),
      .o_rdata_c (w_cmd_head),
      .o_full_c  (w_cmd_full),
      .o_empty_c (w_cmd_empty)
   );

   // Response queue.
   assign w_rsp_in = '{timeout: r_timeout, data: r_rdata};
   // A full response queue still takes a push when its head leaves this cycle.
   assign w_rsp_can_push = !w_rsp_full || bus_if.rsp_ready;

   qcu_sync_fifo #(
      .WIDTH (RSP_W),
      .DEPTH (RSP_DEPTH)
   ) u_rsp_fifo (
      .clk       (clk),
      .rst       (rst),
      .i_push    (w_rsp_push),
      .i_wdata   (w_rsp_in),
      .i_pop     (bus_if.rsp_ready),
      .o_rdata_c (w_rsp_head),
      .o_full_c  (w_rsp_full),
      .o_empty_c (w_rsp_empty)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_next;
   end

   // Next-state and control decode.
   always_comb begin
      w_next        = r_state;
      w_cmd_pop     = 1'b0;
      w_rsp_push    = 1'b0;
      w_set_err     = 1'b0;
      w_capture     = 1'b0;
      w_cap_timeout = 1'b0;
      w_issue_op    = r_cmd.op;
      w_issue_addr  = r_cmd.addr;
      w_issue_wdata = r_cmd.wdata;

      unique case (r_state)
         ST_IDLE: begin
            if (!w_cmd_empty) begin
               w_cmd_pop     = 1'b1;
               // The command is not registered yet; issue straight from the head.
               w_issue_op    = w_cmd_head.op;
               w_issue_addr  = w_cmd_head.addr;
               w_issue_wdata = w_cmd_head.wdata;
               if (w_cmd_head.op == RSVD) w_set_err = 1'b1;
               else                       w_next    = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            w_next = (r_cmd.op == WRITE) ? ST_IDLE : ST_CAPTURE;
         end
         ST_CAPTURE: begin
            w_capture = 1'b1;
            if (r_cmd.op != POLL ||
                poll_match(bus_if.bus_rdata, r_cmd.wdata, r_cmd.mask)) begin
               w_next = ST_RSP_WAIT;
            end else if (r_poll_cnt == CNT_W'(POLL_LIMIT)) begin
               w_cap_timeout = 1'b1;
               w_next        = ST_RSP_WAIT;
            end else begin
               w_next = ST_POLL_GAP;
            end
         end
         ST_POLL_GAP: begin
            w_next = ST_ISSUE;
         end
         ST_RSP_WAIT: begin
            if (w_rsp_can_push) begin
               w_rsp_push = 1'b1;
               w_next     = ST_IDLE;
            end
         end
         default: begin
            w_next = ST_IDLE;
         end
      endcase
   end

   // Bus outputs are registered off the next state so they line up with ISSUE.
   assign w_issue = (w_next == ST_ISSUE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_bus_cs    <= 1'b0;
         r_bus_we    <= 1'b0;
         r_bus_addr  <= '0;
         r_bus_wdata <= '0;
      end else begin
         r_bus_cs    <= w_issue;
         r_bus_we    <= w_issue && (w_issue_op == WRITE);
         r_bus_addr  <= w_issue ? w_issue_addr : '0;
         r_bus_wdata <= (w_issue && (w_issue_op == WRITE)) ? w_issue_wdata : '0;
      end
   end

   // Current command, poll count, captured read data and error flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cmd      <= '0;
         r_poll_cnt <= '0;
         r_rdata    <= '0;
         r_timeout  <= 1'b0;
         r_err_op   <= 1'b0;
      end else begin
         if (w_cmd_pop) begin
            r_cmd      <= w_cmd_head;
            r_poll_cnt <= '0;
         end else if (r_state == ST_ISSUE && r_cmd.op == POLL) begin
            r_poll_cnt <= r_poll_cnt + CNT_W'(1);
         end
         if (w_capture) begin
            r_rdata   <= bus_if.bus_rdata;
            r_timeout <= w_cap_timeout;
         end
         if (w_set_err) r_err_op <= 1'b1;
      end
   end

   assign bus_if.cmd_ready   = !w_cmd_full;
   assign bus_if.rsp_valid   = !w_rsp_empty;
   assign bus_if.rsp_data    = w_rsp_head.data;
   assign bus_if.rsp_timeout = w_rsp_head.timeout;
   assign bus_if.bus_cs      = r_bus_cs;
   assign bus_if.bus_we      = r_bus_we;
   assign bus_if.bus_addr    = r_bus_addr;
   assign bus_if.bus_wdata   = r_bus_wdata;

   assign busy   = (r_state != ST_IDLE) || !w_cmd_empty;
   assign err_op = r_err_op;

endmodule
